// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target responder (MPU9250-style register target).
package i2c_target_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StReg,
        StRegAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataMack,
        StWaitStop
    } state_e;

    localparam logic [6:0] MPU9250_ADDR = 7'h68;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
    localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
    localparam logic [7:0] WHO_AM_I     = 8'h75;

endpackage

// File: rtl/i2c_target_responder_if.sv
// Bus pins plus register-file port of the I2C target responder.
interface i2c_target_responder_if;

    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       ack_err;

    modport slave (
        input  scl_in,
        input  sda_in,
        input  reg_rdata,
        output sda_oe,
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output busy,
        output ack_err
    );

    modport master (
        output scl_in,
        output sda_in,
        output reg_rdata,
        input  sda_oe,
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  busy,
        input  ack_err
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into clk_scl and derives one-cycle edge, START and STOP pulses.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_scl,
    input  logic reset_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_hist_q;
    logic                   sda_hist_q;
    logic                   scl;

    assign scl = scl_sync_q[SYNC_STAGES-1];
    assign sda = sda_sync_q[SYNC_STAGES-1];

    // Idle bus is high, so everything resets to 1 to avoid a spurious edge at release.
    always_ff @(posedge clk_scl or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_hist_q <= scl;
            sda_hist_q <= sda;
        end
    end

    assign scl_rise = scl & ~scl_hist_q;
    assign scl_fall = ~scl & scl_hist_q;
    assign start    = scl & scl_hist_q & sda_hist_q & ~sda;
    assign stop     = scl & scl_hist_q & ~sda_hist_q & sda;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target protocol engine: pointer write, burst write and repeated-START burst read
// against a synchronous register-file port.
module i2c_target_responder
    import i2c_target_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = MPU9250_ADDR,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                    clk_scl,
    input logic                    reset_n,
    i2c_target_responder_if.slave  bus
);

    logic sda, scl_rise, scl_fall, start, stop;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_scl  (clk_scl),
        .reset_n  (reset_n),
        .scl_in   (bus.scl_in),
        .sda_in   (bus.sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       reg_we_q, reg_we_d;
    logic       busy_q, busy_d;
    logic       ack_err_q, ack_err_d;
    logic       rd_nack_q, rd_nack_d;
    logic       nack_fall_q, nack_fall_d;

    always_ff @(posedge clk_scl or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            ack_err_q   <= 1'b0;
            rd_nack_q   <= 1'b0;
            nack_fall_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            busy_q      <= busy_d;
            ack_err_q   <= ack_err_d;
            rd_nack_q   <= rd_nack_d;
            nack_fall_q <= nack_fall_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        busy_d      = busy_q;
        ack_err_d   = ack_err_q;
        rd_nack_d   = rd_nack_q;
        nack_fall_d = nack_fall_q;
        // Pointer advances at the end of the write strobe so the strobe sees the old address.
        reg_addr_d  = reg_we_q ? reg_addr_q + 8'd1 : reg_addr_q;

        if (stop) begin
            state_d   = StIdle;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
        end else if (start) begin
            state_d     = StAddr;
            bit_cnt_d   = '0;
            ack_err_d   = 1'b0;
            sda_oe_d    = 1'b0;
            rd_nack_d   = 1'b0;
            nack_fall_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAddr, StReg, StWdata: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (state_q == StAddr) begin
                            if (shift_q[7:1] == DEV_ADDR) begin
                                busy_d   = 1'b1;
                                sda_oe_d = 1'b1;
                                rw_d     = shift_q[0];
                                state_d  = StAddrAck;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = StWaitStop;
                            end
                        end else if (state_q == StReg) begin
                            reg_addr_d = shift_q;
                            sda_oe_d   = 1'b1;
                            state_d    = StRegAck;
                        end else begin
                            reg_wdata_d = shift_q;
                            reg_we_d    = 1'b1;
                            sda_oe_d    = 1'b1;
                            state_d     = StWdataAck;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            shift_d   = {bus.reg_rdata[6:0], 1'b0};
                            sda_oe_d  = ~bus.reg_rdata[7];
                            bit_cnt_d = 4'd1;
                            state_d   = StRdata;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = StReg;
                        end
                    end
                end
                StRegAck, StWdataAck: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = StWdata;
                    end
                end
                StRdata: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = StRdataMack;
                        end else begin
                            sda_oe_d  = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                StRdataMack: begin
                    if (scl_rise) begin
                        if (sda == ACK) begin
                            reg_addr_d = reg_addr_q + 8'd1;
                        end else begin
                            busy_d    = 1'b0;
                            rd_nack_d = 1'b1;
                            state_d   = StWaitStop;
                        end
                    end
                    // A fall while still here means the preceding rise carried an ACK.
                    if (scl_fall) begin
                        shift_d   = {bus.reg_rdata[6:0], 1'b0};
                        sda_oe_d  = ~bus.reg_rdata[7];
                        bit_cnt_d = 4'd1;
                        state_d   = StRdata;
                    end
                end
                StWaitStop: begin
                    sda_oe_d = 1'b0;
                    // One fall after a read NACK is the normal lead-in to STOP; a second is not.
                    if (rd_nack_q && scl_fall) begin
                        if (nack_fall_q) ack_err_d = 1'b1;
                        nack_fall_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.busy      = busy_q;
    assign bus.ack_err   = ack_err_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Scoreboard bench: a bus monitor decodes 9-bit frames and write strobes and checks them
// against expectations queued by the directed master stimulus.
module tb_i2c_target_responder;
    import i2c_target_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_line;
    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;

    logic [8:0]  exp_frames [$];
    logic [15:0] exp_wr [$];

    i2c_target_responder_if bus ();

    assign sda_line      = sda_drv & ~bus.sda_oe;
    assign bus.scl_in    = scl_drv;
    assign bus.sda_in    = sda_line;
    assign bus.reg_rdata = mem[bus.reg_addr];

    i2c_target_responder #(
        .DEV_ADDR    (MPU9250_ADDR),
        .SYNC_STAGES (2)
    ) dut (
        .clk_scl (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        wait_q(); sda_drv = 1'b1;
        wait_q(); scl_drv = 1'b1;
        wait_q(); sda_drv = 1'b0;
        wait_q(); scl_drv = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_q(); sda_drv = 1'b0;
        wait_q(); scl_drv = 1'b1;
        wait_q(); sda_drv = 1'b1;
        wait_q();
    endtask

    task automatic i2c_bit(input logic b);
        wait_q(); sda_drv = b;
        wait_q(); scl_drv = 1'b1;
        wait_q();
        wait_q(); scl_drv = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack);
        exp_frames.push_back({b, exp_ack});
        for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
        i2c_bit(1'b1);
    endtask

    task automatic read_byte(input logic [7:0] exp_b, input logic mack);
        exp_frames.push_back({exp_b, mack});
        for (int i = 0; i < 8; i++) i2c_bit(1'b1);
        i2c_bit(mack);
    endtask

    // Monitor: decode frames from the wired-AND bus and catch every write strobe.
    initial begin
        logic       ps, pd, s, d;
        int         cnt;
        logic [8:0] fr;
        logic [8:0] ef;
        logic [15:0] ew;
        ps = 1'b1; pd = 1'b1; cnt = 0; fr = '0;
        forever begin
            @(negedge clk);
            s = scl_drv;
            d = sda_line;
            if (ps && s && pd && !d) begin
                cnt = 0;
            end else if (ps && s && !pd && d) begin
                cnt = 0;
            end else if (!ps && s) begin
                fr = {fr[7:0], d};
                cnt++;
                if (cnt == 9) begin
                    cnt = 0;
                    if (exp_frames.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL frame: got unexpected %0h expected none", fr);
                    end else begin
                        ef = exp_frames.pop_front();
                        chk("frame{byte,ack}", {23'd0, fr}, {23'd0, ef});
                    end
                end
            end
            if (bus.reg_we === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL reg_we: got write %0h=%0h expected none",
                             bus.reg_addr, bus.reg_wdata);
                end else begin
                    ew = exp_wr.pop_front();
                    chk("reg_write{addr,data}", {16'd0, bus.reg_addr, bus.reg_wdata},
                        {16'd0, ew});
                end
            end
            ps = s;
            pd = d;
        end
    end

    initial begin
        #2ms;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " sda_oe"},    {31'd0, bus.sda_oe}, 32'd0);
        chk({tag, " reg_addr"},  {24'd0, bus.reg_addr}, 32'd0);
        chk({tag, " reg_wdata"}, {24'd0, bus.reg_wdata}, 32'd0);
        chk({tag, " reg_we"},    {31'd0, bus.reg_we}, 32'd0);
        chk({tag, " busy"},      {31'd0, bus.busy}, 32'd0);
        chk({tag, " ack_err"},   {31'd0, bus.ack_err}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[ACCEL_XOUT_H] = 8'hA5;
        mem[8'hFE]        = 8'h11;
        mem[8'hFF]        = 8'h22;
        mem[8'h00]        = 8'h33;
        mem[WHO_AM_I]     = 8'h71;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // Single register write
        i2c_start();
        write_byte(8'hD0, ACK);
        chk("busy after addr", {31'd0, bus.busy}, 32'd1);
        write_byte(PWR_MGMT_1, ACK);
        exp_wr.push_back({PWR_MGMT_1, 8'h02});
        write_byte(8'h02, ACK);
        i2c_stop();
        wait_q();
        chk("busy after stop", {31'd0, bus.busy}, 32'd0);
        chk("addr after write", {24'd0, bus.reg_addr}, 32'h6C);

        // Repeated-START single read with NACK
        i2c_start();
        write_byte(8'hD0, ACK);
        write_byte(ACCEL_XOUT_H, ACK);
        i2c_start();
        write_byte(8'hD1, ACK);
        read_byte(8'hA5, NACK);
        i2c_stop();
        wait_q();
        chk("busy after read", {31'd0, bus.busy}, 32'd0);
        chk("ack_err after read", {31'd0, bus.ack_err}, 32'd0);

        // Burst read wrapping the pointer
        i2c_start();
        write_byte(8'hD0, ACK);
        write_byte(8'hFE, ACK);
        i2c_start();
        write_byte(8'hD1, ACK);
        read_byte(8'h11, ACK);
        read_byte(8'h22, ACK);
        read_byte(8'h33, NACK);
        i2c_stop();
        wait_q();
        chk("addr wrapped", {24'd0, bus.reg_addr}, 32'h00);

        // Foreign address is ignored
        i2c_start();
        write_byte(8'hD2, NACK);
        chk("busy foreign", {31'd0, bus.busy}, 32'd0);
        write_byte(8'h55, NACK);
        i2c_stop();

        // STOP in the middle of a data byte
        i2c_start();
        write_byte(8'hD0, ACK);
        write_byte(8'h1B, ACK);
        i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1); i2c_bit(1'b0);
        i2c_stop();
        wait_q();
        chk("busy after partial", {31'd0, bus.busy}, 32'd0);
        chk("sda_oe after partial", {31'd0, bus.sda_oe}, 32'd0);

        // Reset while the target drives a 0 data bit
        i2c_start();
        write_byte(8'hD0, ACK);
        write_byte(WHO_AM_I, ACK);
        i2c_start();
        write_byte(8'hD1, ACK);
        wait_q();
        chk("rdata bit7 driven", {31'd0, bus.sda_oe}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("mid-read reset");
        i2c_stop();
        reset_n = 1'b1;
        wait_q();

        // Recovery write after reset
        i2c_start();
        write_byte(8'hD0, ACK);
        write_byte(8'h1B, ACK);
        exp_wr.push_back({8'h1B, 8'h18});
        write_byte(8'h18, ACK);
        i2c_stop();
        wait_q();
        chk("addr after recovery", {24'd0, bus.reg_addr}, 32'h1C);
        chk("wdata after recovery", {24'd0, bus.reg_wdata}, 32'h18);

        wait_q();
        chk("frames left", exp_frames.size(), 32'd0);
        chk("writes left", exp_wr.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
